if_stage_mo: RTL and testbench
==============================

IF_STAGE_MO -- requirements
Module: if_stage_mo

Interface
REQ-001 SHALL have parameter OUTSTANDING, 2, max in-flight instruction requests (1..8, power of 2).
REQ-002 SHALL have parameter BUF_DEPTH, 4, instruction buffer entries (power of 2, >= OUTSTANDING).
REQ-003 SHALL have parameter RESET_PC, 32'hbfc00000, first fetch address after reset.
REQ-004 SHALL have parameter EX_ENTRY, 32'hbfc00380, fetch address on exception flush.
REQ-005 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port ds_allowin  in  1  decode accepts an instruction this cycle.
REQ-008 SHALL have port fs_to_ds_valid  out  1  buffer head valid toward decode.
REQ-009 SHALL have port fs_to_ds_pc  out  32  PC of head entry.
REQ-010 SHALL have port fs_to_ds_inst  out  32  instruction of head entry (0 when adel).
REQ-011 SHALL have port fs_to_ds_adel  out  1  head entry carries misaligned-PC exception.
REQ-012 SHALL have port ex_flush  in  1  exception: flush and refetch from EX_ENTRY.
REQ-013 SHALL have port redirect_valid  in  1  branch/ERET redirect: flush and refetch.
REQ-014 SHALL have port redirect_pc  in  32  redirect target.
REQ-015 SHALL have port inst_req  out  1  request valid to instruction bus.
REQ-016 SHALL have port inst_addr  out  32  request address.
REQ-017 SHALL have port inst_addr_ok  in  1  request accepted (handshake when inst_req && inst_addr_ok).
REQ-018 SHALL have port inst_data_ok  in  1  in-order return of oldest accepted request.
REQ-019 SHALL have port inst_rdata  in  32  returned instruction.

Function
REQ-020 SHALL hold fetch PC register; advance PC+4 on each accepted request.
REQ-021 SHALL assert inst_req only when inflight < OUTSTANDING, inflight + buffered < BUF_DEPTH, PC aligned, not halted, no flush this cycle.
REQ-022 SHALL keep inst_addr stable while inst_req high and addr_ok low.
REQ-023 SHALL push accepted PC into a PC FIFO (depth OUTSTANDING); on valid data_ok pop it and write {pc, rdata, adel=0} to buffer, visible at fs_to_ds_* next cycle (1-cycle latency).
REQ-024 SHALL pop buffer head when fs_to_ds_valid && ds_allowin; simultaneous push and pop at full/empty SHALL be legal.
REQ-025 SHALL, on misaligned PC (pc[1:0]!=0), issue no bus request, write {pc, 0, adel=1} to buffer once in order after all in-flight data, then halt fetch until a flush.
REQ-026 SHALL, on flush (ex_flush priority over redirect_valid), set PC to EX_ENTRY/redirect_pc, empty buffer and PC FIFO at next edge, force fs_to_ds_valid=0 in the flush cycle, clear halt.
REQ-027 SHALL set discard counter at flush = inflight + (handshake this cycle) - (data_ok this cycle); each later data_ok with counter>0 SHALL be dropped and decrement it.
REQ-028 SHALL count in-flight requests toward inst_req gating while discard counter nonzero (total outstanding never exceeds OUTSTANDING).
REQ-029 SHALL treat flush coincident with data_ok as dropping that data.
REQ-030 SHALL accept back-to-back flushes; the later target wins, discard count accumulates correctly.

Reset
REQ-031 SHALL, during reset, drive inst_req=0, fs_to_ds_valid=0, inflight=0, discard=0, buffer empty, halt=0, PC=RESET_PC.
REQ-032 SHALL allow inst_req=1 with inst_addr=RESET_PC in first cycle after reset deasserts.
REQ-033 SHALL treat reset mid-transaction as abandoning all outstanding requests; the bus is reset concurrently.

Structure
REQ-034 SHALL take RESET_PC/EX_ENTRY defaults and exception-code constants from the shared mycpu header.
REQ-035 SHALL instantiate a parametrised sub-module sync_fifo (WIDTH, DEPTH, push/pop/full/empty/flush) twice: PC FIFO and instruction buffer (width 65).

Verification
REQ-036 SHALL cover: addr_ok/data_ok every cycle, ds_allowin=1 -> one instruction/cycle, PCs bfc00000, bfc00004, ... in order.
REQ-037 SHALL cover: ds_allowin=0, OUTSTANDING=2, BUF_DEPTH=4 -> inst_req drops after 4 accepted requests; resumes the cycle after first pop.
REQ-038 SHALL cover: 2 requests in flight, redirect_valid with redirect_pc=bfc00100 -> next 2 data_ok dropped, next delivered pc=bfc00100.
REQ-039 SHALL cover: ex_flush and redirect_valid same cycle -> fetch resumes at bfc00380.
REQ-040 SHALL cover: redirect_pc=bfc00102 -> no bus request, one entry pc=bfc00102 adel=1 inst=0, inst_req stays 0 until next flush.
REQ-041 SHALL cover: reset asserted with 2 in flight -> all outputs at reset values next cycle; first request RESET_PC after deassert.

Source files
------------

// File: rtl/if_stage_mo_pkg.sv
// Shared fetch-stage definitions: boot/exception vectors, exception codes,
// the instruction-buffer entry layout and a PC alignment helper.
package if_stage_mo_pkg;

   localparam logic [31:0] MYCPU_RESET_PC = 32'hbfc00000;
   localparam logic [31:0] MYCPU_EX_ENTRY = 32'hbfc00380;

   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } fs_entry_t;

   localparam int ENTRY_W = $bits(fs_entry_t);

   function automatic logic pc_aligned(input logic [31:0] pc);
      return pc[1:0] == 2'b00;
   endfunction

   // Exception code a decode stage should raise for a buffer entry.
   function automatic logic [4:0] entry_exc_code(input logic adel);
      return adel ? EXC_ADEL : EXC_INT;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head read and single-cycle flush.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   i_flush         empty the FIFO at the next edge
//   i_push, i_din   write request and data (accepted when not full, or full
//                   with a pop in the same cycle)
//   i_pop           remove head (ignored when empty)
//   o_dout          head entry
//   o_full, o_empty, o_count  occupancy
module sync_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 2,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
         else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: rtl/if_stage_mo.sv
// Instruction fetch stage with multiple outstanding bus requests.
// Requests go out in PC order; returning data is matched to its PC through a
// PC FIFO and lands in an instruction buffer that feeds decode. Flushes
// (exception or redirect) drop everything buffered and arm a discard counter
// that swallows returns belonging to the abandoned requests.
// Ports:
//   clk, reset                           clock, synchronous active-high reset
//   ds_allowin                           decode accepts head this cycle
//   fs_to_ds_valid/pc/inst/adel          buffer head toward decode
//   ex_flush                             refetch from EX_ENTRY (wins)
//   redirect_valid, redirect_pc          refetch from redirect_pc
//   inst_req, inst_addr                  bus request
//   inst_addr_ok, inst_data_ok, inst_rdata  bus handshake / in-order return
module if_stage_mo
   import if_stage_mo_pkg::*;
#(
   parameter int          OUTSTANDING = 2,
   parameter int          BUF_DEPTH   = 4,
   parameter logic [31:0] RESET_PC    = MYCPU_RESET_PC,
   parameter logic [31:0] EX_ENTRY    = MYCPU_EX_ENTRY
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ds_allowin,
   output logic        fs_to_ds_valid,
   output logic [31:0] fs_to_ds_pc,
   output logic [31:0] fs_to_ds_inst,
   output logic        fs_to_ds_adel,
   input  logic        ex_flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata
);

   localparam int OW = $clog2(OUTSTANDING) + 1;
   localparam int BW = $clog2(BUF_DEPTH) + 1;

   logic [31:0]   r_pc;
   logic          r_halt;
   logic [OW-1:0] r_discard;

   logic          w_flush;
   logic [31:0]   w_target;
   logic [OW-1:0] w_inflight;
   logic          w_hs;
   logic          w_dok;
   logic          w_pcf_pop;
   logic          w_adel_wr;
   logic          w_buf_push;
   fs_entry_t     w_buf_din;
   fs_entry_t     w_buf_dout;
   logic          w_buf_full;
   logic          w_buf_empty;
   logic [BW-1:0] w_buf_count;
   logic [31:0]   w_pcf_dout;
   logic          w_pcf_full;
   logic          w_pcf_empty;
   logic [OW-1:0] w_pcf_count;

   assign w_flush  = ex_flush || redirect_valid;
   assign w_target = ex_flush ? EX_ENTRY : redirect_pc;

   // Live requests sit in the PC FIFO; abandoned ones are only counted.
   assign w_inflight = w_pcf_count + r_discard;

   assign inst_req  = !reset && !w_flush && !r_halt && pc_aligned(r_pc)
                      && (32'(w_inflight) < 32'(OUTSTANDING))
                      && (32'(w_inflight) + 32'(w_buf_count) < 32'(BUF_DEPTH))
                      && !w_pcf_full;
   assign inst_addr = r_pc;
   assign w_hs      = inst_req && inst_addr_ok;

   assign w_dok     = inst_data_ok && (w_inflight != '0);
   assign w_pcf_pop = w_dok && (r_discard == '0) && !w_pcf_empty;

   // Misaligned PC: the error entry waits until every earlier return is in.
   assign w_adel_wr = !w_flush && !r_halt && !pc_aligned(r_pc)
                      && (w_inflight == '0) && !w_buf_full;

   assign w_buf_push = (w_pcf_pop && !w_flush) || w_adel_wr;
   assign w_buf_din  = w_adel_wr ? '{pc: r_pc, inst: 32'h0, adel: 1'b1}
                                 : '{pc: w_pcf_dout, inst: inst_rdata, adel: 1'b0};

   assign fs_to_ds_valid = !reset && !w_flush && !w_buf_empty;
   assign fs_to_ds_pc    = w_buf_dout.pc;
   assign fs_to_ds_inst  = w_buf_dout.inst;
   assign fs_to_ds_adel  = w_buf_dout.adel;

   sync_fifo #(.WIDTH(32), .DEPTH(OUTSTANDING)) u_pc_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_flush (w_flush),
      .i_push  (w_hs),
      .i_din   (r_pc),
      .i_pop   (w_pcf_pop),
      .o_dout  (w_pcf_dout),
      .o_full  (w_pcf_full),
      .o_empty (w_pcf_empty),
      .o_count (w_pcf_count)
   );

   sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(BUF_DEPTH)) u_inst_buf (
      .clk     (clk),
      .reset   (reset),
      .i_flush (w_flush),
      .i_push  (w_buf_push),
      .i_din   (w_buf_din),
      .i_pop   (fs_to_ds_valid && ds_allowin),
      .o_dout  (w_buf_dout),
      .o_full  (w_buf_full),
      .o_empty (w_buf_empty),
      .o_count (w_buf_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc      <= RESET_PC;
         r_halt    <= 1'b0;
         r_discard <= '0;
      end else if (w_flush) begin
         r_pc      <= w_target;
         r_halt    <= 1'b0;
         // Everything still on the bus after this edge belongs to the old path.
         r_discard <= w_inflight + OW'(w_hs) - OW'(w_dok);
      end else begin
         if (w_hs)      r_pc   <= r_pc + 32'd4;
         if (w_adel_wr) r_halt <= 1'b1;
         if (w_dok && (r_discard != '0)) r_discard <= r_discard - 1'b1;
      end
   end

endmodule

// File: tb/tb_if_stage_mo.sv
module tb_if_stage_mo;

   localparam int          OUT = 2;
   localparam int          BUF = 4;
   localparam logic [31:0] RPC = 32'hbfc00000;
   localparam logic [31:0] EXE = 32'hbfc00380;

   logic        clk = 1'b0;
   logic        reset;
   logic        ds_allowin;
   logic        fs_to_ds_valid;
   logic [31:0] fs_to_ds_pc;
   logic [31:0] fs_to_ds_inst;
   logic        fs_to_ds_adel;
   logic        ex_flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   if_stage_mo #(.OUTSTANDING(OUT), .BUF_DEPTH(BUF), .RESET_PC(RPC), .EX_ENTRY(EXE)) dut (
      .clk            (clk),
      .reset          (reset),
      .ds_allowin     (ds_allowin),
      .fs_to_ds_valid (fs_to_ds_valid),
      .fs_to_ds_pc    (fs_to_ds_pc),
      .fs_to_ds_inst  (fs_to_ds_inst),
      .fs_to_ds_adel  (fs_to_ds_adel),
      .ex_flush       (ex_flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_req       (inst_req),
      .inst_addr      (inst_addr),
      .inst_addr_ok   (inst_addr_ok),
      .inst_data_ok   (inst_data_ok),
      .inst_rdata     (inst_rdata)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; bit keep; } out_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; bit adel; } ent_t;

   // Reference model: requests on the bus (with a "still wanted" flag) and
   // the queue of instructions waiting for decode.
   out_t        m_out[$];
   ent_t        m_buf[$];
   logic [31:0] m_pc = RPC;
   bit          m_halt = 1'b0;

   logic [31:0] bus_q[$];
   ent_t        dlv[$];

   int          n_total = 0;
   int          n_bad   = 0;
   int          acc_cnt = 0;
   int          p_addr = 100, p_data = 100, p_allow = 100, p_flush = 0;
   bit          k_reset = 1'b1, k_ex = 1'b0, k_redir = 1'b0;
   logic [31:0] k_rpc = 32'h0;

   function automatic logic [31:0] mem_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h3c1a5a5a;
   endfunction

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      t = {16'hbfc0, 16'($urandom)};
      if ($urandom_range(7) != 0) t[1:0] = 2'b00;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      bit          flush, exp_req, exp_valid, hs, adel_wr;
      logic [31:0] tgt;
      out_t        o;
      int          r;
      @(posedge clk);
      #1;
      reset          = k_reset;
      inst_addr_ok   = ($urandom_range(99) < p_addr);
      inst_data_ok   = !k_reset && (bus_q.size() > 0) && ($urandom_range(99) < p_data);
      inst_rdata     = (bus_q.size() > 0) ? mem_of(bus_q[0]) : $urandom;
      ds_allowin     = ($urandom_range(99) < p_allow);
      ex_flush       = k_ex;
      redirect_valid = k_redir;
      redirect_pc    = k_rpc;
      if (!k_ex && !k_redir && p_flush > 0) begin
         r              = $urandom_range(99);
         ex_flush       = (r < 2);
         redirect_valid = (r >= 1) && (r < p_flush);
         redirect_pc    = rand_target();
      end
      #1;
      flush     = ex_flush || redirect_valid;
      tgt       = ex_flush ? EXE : redirect_pc;
      exp_req   = !reset && !flush && !m_halt && (m_pc[1:0] == 2'b00)
                  && (m_out.size() < OUT) && (m_out.size() + m_buf.size() < BUF);
      exp_valid = !reset && !flush && (m_buf.size() > 0);

      chk("inst_req", inst_req, exp_req);
      chk("fs_valid", fs_to_ds_valid, exp_valid);
      if (exp_req) chk("inst_addr", inst_addr, m_pc);
      if (exp_valid) begin
         chk("fs_pc", fs_to_ds_pc, m_buf[0].pc);
         chk("fs_inst", fs_to_ds_inst, m_buf[0].inst);
         chk("fs_adel", fs_to_ds_adel, m_buf[0].adel);
      end

      if (inst_req && inst_addr_ok) begin
         acc_cnt++;
         bus_q.push_back(inst_addr);
      end
      if (inst_data_ok) void'(bus_q.pop_front());
      if (reset) bus_q.delete();
      if (fs_to_ds_valid && ds_allowin)
         dlv.push_back('{fs_to_ds_pc, fs_to_ds_inst, fs_to_ds_adel});

      hs = exp_req && inst_addr_ok;
      if (reset) begin
         m_pc   = RPC;
         m_halt = 1'b0;
         m_out.delete();
         m_buf.delete();
      end else begin
         adel_wr = !flush && !m_halt && (m_pc[1:0] != 2'b00)
                   && (m_out.size() == 0) && (m_buf.size() < BUF);
         if (exp_valid && ds_allowin) void'(m_buf.pop_front());
         if (inst_data_ok && m_out.size() > 0) begin
            o = m_out.pop_front();
            if (o.keep && !flush) m_buf.push_back('{o.pc, mem_of(o.pc), 1'b0});
         end
         if (flush) begin
            foreach (m_out[i]) m_out[i].keep = 1'b0;
            m_buf.delete();
            m_pc   = tgt;
            m_halt = 1'b0;
         end else begin
            if (hs) begin
               m_out.push_back('{m_pc, 1'b1});
               m_pc = m_pc + 32'd4;
            end
            if (adel_wr) begin
               m_buf.push_back('{m_pc, 32'h0, 1'b1});
               m_halt = 1'b1;
            end
         end
      end
      k_ex    = 1'b0;
      k_redir = 1'b0;
   endtask

   task automatic wait_dlv(input string name, input int lim);
      for (int n = 0; n < lim && dlv.size() == 0; n++) tick();
      chk(name, dlv.size() > 0, 1);
   endtask

   initial begin
      reset = 1'b1; ds_allowin = 1'b0; ex_flush = 1'b0; redirect_valid = 1'b0;
      redirect_pc = 32'h0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;

      // Streaming: full-rate bus and decode
      k_reset = 1'b1; tick();
      chk("rst_req", inst_req, 0);
      chk("rst_valid", fs_to_ds_valid, 0);
      k_reset = 1'b0; dlv.delete(); tick();
      chk("first_req", inst_req, 1);
      chk("first_addr", inst_addr, RPC);
      repeat (11) tick();
      chk("stream_cnt", dlv.size() >= 8, 1);
      for (int i = 0; i < 4; i++)
         if (i < dlv.size()) chk("stream_pc", dlv[i].pc, RPC + 32'(4 * i));

      // Back-pressure: buffer fills, request resumes after one pop
      k_reset = 1'b1; tick();
      k_reset = 1'b0; p_allow = 0; acc_cnt = 0;
      repeat (10) tick();
      chk("bp_accepted", acc_cnt, 4);
      chk("bp_req_low", inst_req, 0);
      p_allow = 100; tick();
      p_allow = 0; tick();
      chk("bp_resume", inst_req, 1);

      // Redirect with two requests in flight
      k_reset = 1'b1; tick();
      k_reset = 1'b0; p_allow = 100; p_data = 0; acc_cnt = 0;
      repeat (4) tick();
      chk("rd_inflight", acc_cnt, 2);
      p_data = 100; k_redir = 1'b1; k_rpc = 32'hbfc00100; dlv.delete(); tick();
      wait_dlv("rd_seen", 40);
      if (dlv.size() > 0) chk("rd_first_pc", dlv[0].pc, 32'hbfc00100);

      // Exception and redirect together: exception wins
      k_ex = 1'b1; k_redir = 1'b1; k_rpc = 32'hbfc00100; dlv.delete(); tick();
      tick();
      chk("ex_addr", inst_addr, EXE);
      wait_dlv("ex_seen", 40);
      if (dlv.size() > 0) chk("ex_first_pc", dlv[0].pc, EXE);

      // Misaligned redirect target
      k_redir = 1'b1; k_rpc = 32'hbfc00102; tick();
      acc_cnt = 0; dlv.delete();
      repeat (12) tick();
      chk("adel_no_req", acc_cnt, 0);
      chk("adel_halt", inst_req, 0);
      chk("adel_cnt", dlv.size(), 1);
      if (dlv.size() > 0) begin
         chk("adel_pc", dlv[0].pc, 32'hbfc00102);
         chk("adel_inst", dlv[0].inst, 32'h0);
         chk("adel_flag", dlv[0].adel, 1);
      end

      // Reset with two requests in flight
      k_redir = 1'b1; k_rpc = 32'hbfc00200; p_data = 0; acc_cnt = 0; tick();
      repeat (4) tick();
      chk("mr_inflight", acc_cnt, 2);
      k_reset = 1'b1; tick();
      chk("mr_req", inst_req, 0);
      chk("mr_valid", fs_to_ds_valid, 0);
      k_reset = 1'b0; p_data = 100; tick();
      chk("mr_post_req", inst_req, 1);
      chk("mr_post_addr", inst_addr, RPC);
      chk("mr_post_valid", fs_to_ds_valid, 0);

      // Randomized traffic
      for (int seg = 0; seg < 8; seg++) begin
         p_addr  = $urandom_range(30, 100);
         p_data  = $urandom_range(20, 100);
         p_allow = $urandom_range(10, 100);
         p_flush = $urandom_range(0, 8);
         repeat (400) begin
            k_reset = ($urandom_range(299) == 0);
            tick();
         end
      end
      k_reset = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
